// File: rtl/arith_cmpf_arbiter_if.sv
// Bundle of the requester-side and comparator-side handshakes of arith_cmpf_arbiter.
//   req_*  : per-requester operand pairs (valid/ready); operand i at [i*WIDTH +: WIDTH]
//   resp_* : per-requester 1-bit results (valid/ready)
//   cmp_*  : join handshake towards the shared floating-point comparator
// slave  = arbiter view, master = requesters + comparator view.
interface arith_cmpf_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [NUM_REQ-1:0]       resp_ready;
  logic [NUM_REQ-1:0]       resp_data;
  logic                     cmp_a_valid;
  logic                     cmp_b_valid;
  logic                     cmp_a_ready;
  logic                     cmp_b_ready;
  logic [WIDTH-1:0]         cmp_a_data;
  logic [WIDTH-1:0]         cmp_b_data;
  logic                     cmp_result_valid;
  logic                     cmp_result_ready;
  logic                     cmp_result_data;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    input  cmp_a_ready, cmp_b_ready, cmp_result_valid, cmp_result_data,
    output req_ready, resp_valid, resp_data,
    output cmp_a_valid, cmp_b_valid, cmp_a_data, cmp_b_data, cmp_result_ready
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    output cmp_a_ready, cmp_b_ready, cmp_result_valid, cmp_result_data,
    input  req_ready, resp_valid, resp_data,
    input  cmp_a_valid, cmp_b_valid, cmp_a_data, cmp_b_data, cmp_result_ready
  );
endinterface

// File: rtl/arith_cmpf_arbiter.sv
// Round-robin arbiter time-multiplexing one external FP comparator among NUM_REQ
// requesters. The winner's operands are held in an issue register that drives the
// comparator join handshake; the 1-bit result lands in the owner's response slot.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : arith_cmpf_arbiter_if.slave (requester, response and comparator handshakes)
//   op_count   : completed comparisons, wraps modulo 2^32
module arith_cmpf_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  arith_cmpf_arbiter_if.slave  bus,
  output logic [31:0]          op_count
);

  localparam int unsigned OWN_W = $clog2(NUM_REQ);

  // Elaboration-time parameter legality
  if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $fatal(1, "arith_cmpf_arbiter: WIDTH must be 32 or 64");
  end
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $fatal(1, "arith_cmpf_arbiter: NUM_REQ must be in 2..16");
  end

  logic                 iss_valid;
  logic [OWN_W-1:0]     iss_owner;
  logic [WIDTH-1:0]     iss_a;
  logic [WIDTH-1:0]     iss_b;
  logic [OWN_W-1:0]     last_grant;
  logic [NUM_REQ-1:0]   resp_valid_q;
  logic [NUM_REQ-1:0]   resp_data_q;

  logic                 complete_c;
  logic                 free_c;
  logic [NUM_REQ-1:0]   eligible_c;
  logic                 win_c;
  logic                 grant_c;
  logic [OWN_W-1:0]     grant_idx_c;
  logic [OWN_W-1:0]     idx_c;
  logic [WIDTH-1:0]     grant_a_c;
  logic [WIDTH-1:0]     grant_b_c;
  logic [NUM_REQ-1:0]   ready_c;

  // Completion of the comparator join; the register is reusable in the same cycle
  assign complete_c = iss_valid & bus.cmp_result_valid & bus.cmp_a_ready & bus.cmp_b_ready;
  assign free_c     = ~iss_valid | complete_c;

  // One outstanding op per requester: busy while in the issue register or response slot
  always_comb begin : eligibility
    eligible_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      eligible_c[i] = bus.req_valid[i] & ~resp_valid_q[i]
                    & ~(iss_valid & (iss_owner == OWN_W'(i)));
    end
  end

  // Round-robin search starting just after the last grant
  always_comb begin : rr_search
    win_c       = 1'b0;
    grant_idx_c = '0;
    idx_c       = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx_c = OWN_W'((32'(last_grant) + k) % NUM_REQ);
      if (!win_c && eligible_c[idx_c]) begin
        win_c       = 1'b1;
        grant_idx_c = idx_c;
      end
    end
  end

  // Reset gating keeps req_ready low while rst_n is asserted even with valids pending
  assign grant_c = win_c & free_c & rst_n;

  always_comb begin : ready_decode
    ready_c = '0;
    if (grant_c) ready_c[grant_idx_c] = 1'b1;
  end

  // Winner operand mux
  always_comb begin : operand_mux
    grant_a_c = '0;
    grant_b_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_c == OWN_W'(i)) begin
        grant_a_c = bus.req_a[i*WIDTH +: WIDTH];
        grant_b_c = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Issue register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin : issue_reg
    if (!rst_n) begin
      iss_valid  <= 1'b0;
      iss_owner  <= '0;
      iss_a      <= '0;
      iss_b      <= '0;
      last_grant <= OWN_W'(NUM_REQ - 1);
    end else if (grant_c) begin
      iss_valid  <= 1'b1;
      iss_owner  <= grant_idx_c;
      iss_a      <= grant_a_c;
      iss_b      <= grant_b_c;
      last_grant <= grant_idx_c;
    end else if (complete_c) begin
      iss_valid  <= 1'b0;
    end
  end

  // Per-requester response slots; the owner's slot is always empty at completion
  always_ff @(posedge clk or negedge rst_n) begin : resp_reg
    if (!rst_n) begin
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (complete_c && (iss_owner == OWN_W'(i))) begin
          resp_valid_q[i] <= 1'b1;
          resp_data_q[i]  <= bus.cmp_result_data;
        end else if (resp_valid_q[i] && bus.resp_ready[i]) begin
          resp_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  // Completed-operation counter
  always_ff @(posedge clk or negedge rst_n) begin : op_counter
    if (!rst_n) begin
      op_count <= '0;
    end else if (complete_c) begin
      op_count <= op_count + 32'd1;
    end
  end

  assign bus.req_ready        = ready_c;
  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_data        = resp_data_q;
  assign bus.cmp_a_valid      = iss_valid;
  assign bus.cmp_b_valid      = iss_valid;
  assign bus.cmp_a_data       = iss_a;
  assign bus.cmp_b_data       = iss_b;
  assign bus.cmp_result_ready = iss_valid;

endmodule

// File: tb/tb_arith_cmpf_arbiter.sv
// Bench for arith_cmpf_arbiter: transaction-level model of the arbitration rules plus a
// per-requester result scoreboard drained by an independent response monitor.
module tb_arith_cmpf_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  arith_cmpf_arbiter_if #(.NUM_REQ(N), .WIDTH(W))  bus ();
  arith_cmpf_arbiter_if #(.NUM_REQ(N), .WIDTH(64)) bus64 ();
  logic [31:0] op_count;
  logic [31:0] op_count64;

  arith_cmpf_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .op_count(op_count));
  arith_cmpf_arbiter #(.NUM_REQ(N), .WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(bus64), .op_count(op_count64));

  // IEEE single ordered-less-than (predicate olt)
  function automatic logic olt32(input logic [31:0] x, input logic [31:0] y);
    logic nx, ny;
    nx = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    ny = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    if (nx || ny) return 1'b0;
    if (x[30:0] == 0 && y[30:0] == 0) return 1'b0;
    if (x[31] != y[31]) return x[31];
    if (!x[31]) return x[30:0] < y[30:0];
    return x[30:0] > y[30:0];
  endfunction

  // IEEE double unordered (predicate uno)
  function automatic logic uno64(input logic [63:0] x, input logic [63:0] y);
    return ((x[62:52] == 11'h7FF) && (x[51:0] != 0)) ||
           ((y[62:52] == 11'h7FF) && (y[51:0] != 0));
  endfunction

  // Behavioural comparators (combinationally ready unless stalled)
  logic stall_a, stall_b, stall_r;
  assign bus.cmp_a_ready      = ~stall_a;
  assign bus.cmp_b_ready      = ~stall_b;
  assign bus.cmp_result_valid = bus.cmp_a_valid & ~stall_r;
  assign bus.cmp_result_data  = olt32(bus.cmp_a_data, bus.cmp_b_data);
  assign bus64.cmp_a_ready      = 1'b1;
  assign bus64.cmp_b_ready      = 1'b1;
  assign bus64.cmp_result_valid = bus64.cmp_a_valid;
  assign bus64.cmp_result_data  = uno64(bus64.cmp_a_data, bus64.cmp_b_data);

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [N-1:0] m_rv;
  int           m_infl;
  int           m_last;
  int unsigned  m_ops;
  logic [31:0]  m_ia, m_ib;
  logic         exp_q [N][$];

  // Stimulus state and knobs
  logic [N-1:0] pv;
  logic [31:0]  sa [N];
  logic [31:0]  sb [N];
  logic [N-1:0] valid_en, rr_off;
  int           p_valid, p_rready, p_stall;
  bit           stall_force;
  int           dut_grants[$];

  function automatic logic [31:0] rand_fp();
    case ($urandom_range(5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FC0_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic model_reset();
    m_rv = '0; m_infl = -1; m_last = int'(N) - 1; m_ops = 0;
    m_ia = '0; m_ib = '0;
    for (int i = 0; i < int'(N); i++) exp_q[i].delete();
  endtask

  // One clock cycle: drive at negedge, compare at negedge+1, advance model
  task automatic step();
    logic [N-1:0]   rr;
    logic [N*W-1:0] va, vb;
    logic [N-1:0]   exp_rdy;
    bit             cmp_ok, free;
    int             win;
    @(negedge clk);
    for (int i = 0; i < int'(N); i++) begin
      if (!pv[i] && valid_en[i] && $urandom_range(99) < p_valid) begin
        pv[i] = 1'b1;
        sa[i] = rand_fp();
        sb[i] = ($urandom_range(3) == 0) ? sa[i] : rand_fp();
      end
      va[i*W +: W] = sa[i];
      vb[i*W +: W] = sb[i];
      rr[i] = !rr_off[i] && ($urandom_range(99) < p_rready);
    end
    bus.req_valid  = pv;
    bus.req_a      = va;
    bus.req_b      = vb;
    bus.resp_ready = rr;
    stall_a = stall_force || ($urandom_range(99) < p_stall);
    stall_b = $urandom_range(99) < p_stall;
    stall_r = $urandom_range(99) < p_stall;
    #1;
    check("op_count", 64'(op_count), 64'(m_ops));
    check("resp_valid", 64'(bus.resp_valid), 64'(m_rv));
    check("cmp_valid", 64'({bus.cmp_a_valid, bus.cmp_b_valid, bus.cmp_result_ready}),
          (m_infl >= 0) ? 64'd7 : 64'd0);
    if (m_infl >= 0) begin
      check("cmp_a_data", 64'(bus.cmp_a_data), 64'(m_ia));
      check("cmp_b_data", 64'(bus.cmp_b_data), 64'(m_ib));
    end
    cmp_ok = (m_infl >= 0) && !stall_a && !stall_b && !stall_r;
    free   = (m_infl < 0) || cmp_ok;
    win    = -1;
    if (free) begin
      for (int k = 1; k <= int'(N); k++) begin
        int j;
        j = (m_last + k) % int'(N);
        if (win < 0 && pv[j] && !m_rv[j] && m_infl != j) win = j;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    for (int i = 0; i < int'(N); i++) if (bus.req_ready[i]) dut_grants.push_back(i);
    for (int i = 0; i < int'(N); i++) if (m_rv[i] && rr[i]) m_rv[i] = 1'b0;
    if (cmp_ok) begin
      m_rv[m_infl] = 1'b1;
      m_ops++;
    end
    if (win >= 0) begin
      exp_q[win].push_back(olt32(sa[win], sb[win]));
      m_ia = sa[win]; m_ib = sb[win];
      m_infl = win; m_last = win;
      pv[win] = 1'b0;
    end else if (cmp_ok) begin
      m_infl = -1;
    end
  endtask

  // Response monitor: pops the scoreboard whenever a response is consumed
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        for (int i = 0; i < int'(N); i++) begin
          if (bus.resp_valid[i] && bus.resp_ready[i]) begin
            if (exp_q[i].size() == 0) check("resp_unexpected", 64'(i), 64'hFF);
            else check("resp_data", 64'(bus.resp_data[i]), 64'(exp_q[i].pop_front()));
          end
        end
      end
    end
  end

  task automatic op64(input logic [63:0] x, input logic [63:0] y, input logic expv,
                      input string nm);
    int t;
    @(negedge clk);
    bus64.req_a[3*64 +: 64] = x;
    bus64.req_b[3*64 +: 64] = y;
    bus64.req_valid = 4'b1000;
    #1;
    t = 0;
    while (!bus64.req_ready[3] && t < 10) begin @(negedge clk); #1; t++; end
    check({nm, "_grant"}, 64'(bus64.req_ready[3]), 64'd1);
    @(negedge clk);
    bus64.req_valid = '0;
    #1;
    t = 0;
    while (!bus64.resp_valid[3] && t < 10) begin @(negedge clk); #1; t++; end
    check({nm, "_resp_valid"}, 64'(bus64.resp_valid[3]), 64'd1);
    check(nm, 64'(bus64.resp_data[3]), 64'(expv));
  endtask

  initial begin
    int g [N];
    int t;
    int busy_at_stall;
    bit reached;
    pv = '0; valid_en = '0; rr_off = '0; stall_force = 1'b0;
    p_valid = 0; p_rready = 100; p_stall = 0;
    for (int i = 0; i < int'(N); i++) begin sa[i] = '0; sb[i] = '0; end
    stall_a = 1'b0; stall_b = 1'b0; stall_r = 1'b0;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.resp_ready = '0;
    bus64.req_valid = '0; bus64.req_a = '0; bus64.req_b = '0; bus64.resp_ready = '1;
    model_reset();

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_resp", 64'({bus.resp_valid, bus.resp_data}), 64'd0);
    check("rst_cmp", 64'({bus.cmp_a_valid, bus.cmp_b_valid, bus.cmp_result_ready}), 64'd0);
    check("rst_op_count", 64'(op_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single op: 1.0 olt 2.0 from requester 0
    pv[0] = 1'b1; sa[0] = 32'h3F80_0000; sb[0] = 32'h4000_0000;
    step();
    check("single_grant", 64'(bus.req_ready), 64'd1);
    step();
    step();
    check("single_resp", 64'({bus.resp_valid[0], bus.resp_data[0]}), 64'd3);
    check("single_op_count", 64'(op_count), 64'd1);

    // Round-robin fairness with all requesters busy and immediate pops
    valid_en = '1; p_valid = 100; p_rready = 100;
    dut_grants.delete();
    repeat (12) step();
    check("rr_grant_count", 64'(dut_grants.size()), 64'd12);
    for (int k = 0; k < dut_grants.size(); k++)
      check("rr_order", 64'(dut_grants[k]), 64'((1 + k) % int'(N)));

    // Response backpressure on requester 1
    rr_off = 4'b0010;
    dut_grants.delete();
    repeat (10) step();
    for (int i = 0; i < int'(N); i++) g[i] = 0;
    foreach (dut_grants[k]) g[dut_grants[k]]++;
    check("bp_grants_to_1", 64'(g[1] <= 1), 64'd1);
    check("bp_others_served", 64'(g[0] >= 2 && g[2] >= 2 && g[3] >= 2), 64'd1);
    rr_off = '0;

    // Comparator stall on operand a
    busy_at_stall = (m_infl >= 0) ? 1 : 0;
    stall_force = 1'b1;
    dut_grants.delete();
    repeat (5) step();
    check("stall_no_grant", 64'(dut_grants.size()), 64'(1 - busy_at_stall));
    stall_force = 1'b0;
    step();
    check("stall_release_grant", 64'(bus.req_ready != 0), 64'd1);

    // Randomized traffic
    p_valid = 60; p_rready = 70; p_stall = 20;
    repeat (1500) step();

    // Reset mid-flight with requester 2's response pending
    p_valid = 100; p_rready = 100; p_stall = 0; rr_off = 4'b0100;
    reached = 1'b0;
    t = 0;
    while (!reached && t < 40) begin
      step();
      reached = m_rv[2] && (m_infl >= 0);
      t++;
    end
    check("reset_setup", 64'(reached), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 64'(bus.req_ready), 64'd0);
    check("midrst_resp", 64'({bus.resp_valid, bus.resp_data}), 64'd0);
    check("midrst_cmp", 64'({bus.cmp_a_valid, bus.cmp_b_valid, bus.cmp_result_ready}), 64'd0);
    check("midrst_op_count", 64'(op_count), 64'd0);
    model_reset();
    pv = '0; rr_off = '0;
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dut_grants.delete();
    step();
    check("post_rst_grants", 64'(dut_grants.size()), 64'd1);
    if (dut_grants.size() > 0) check("post_rst_first", 64'(dut_grants[0]), 64'd0);
    p_valid = 50; p_rready = 80; p_stall = 10;
    repeat (30) step();

    // Drain and confirm no result was lost
    valid_en = '0; p_rready = 100; p_stall = 0;
    repeat (10) step();
    for (int i = 0; i < int'(N); i++) check("drain_q", 64'(exp_q[i].size()), 64'd0);

    // 64-bit instance: uno with a quiet NaN, then an ordered pair
    op64(64'h7FF8_0000_0000_0000, 64'h3FF0_0000_0000_0000, 1'b1, "nan_uno");
    op64(64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, "uno_ordered");
    @(negedge clk);
    #1;
    check("op_count64", 64'(op_count64), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
